// File: rtl/data_memory_unit.sv
// Load/store responder: byte/half/word little-endian accesses on a word RAM,
// with word-crossing accesses split over two cycles by a two-state FSM.
module data_memory_unit #(
  parameter int DEPTH_WORDS = 1024,
  parameter int INDEX_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic        memory_write_enable,
  input  logic [2:0]  memory_split_option,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        response_valid,
  output logic [31:0] read_data,
  output logic        fault
);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t state, state_next;

  logic [31:0] mem [DEPTH_WORDS];

  logic [INDEX_WIDTH-1:0] index, half_index, half_index_next, wr_index;
  logic [1:0]  offset, half_offset, half_offset_next;
  logic [3:0]  size, size_mask;
  logic        legal, crossing;
  logic [63:0] wide_data;
  logic [7:0]  wide_be;
  logic [31:0] half_wdata, half_wdata_next, half_low, half_low_next;
  logic [3:0]  half_be, half_be_next, wr_be;
  logic        half_store, half_store_next;
  logic [2:0]  half_option, half_option_next;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        valid_next, fault_next;
  logic [31:0] data_next;
  logic        unused_address;

  assign unused_address = ^address[31:INDEX_WIDTH+2];

  assign index  = address[INDEX_WIDTH+1:2];
  assign offset = address[1:0];

  always_comb begin
    size      = 4'd4;
    size_mask = 4'b1111;
    case (memory_split_option[1:0])
      2'b00:   begin size = 4'd1; size_mask = 4'b0001; end
      2'b01:   begin size = 4'd2; size_mask = 4'b0011; end
      default: begin size = 4'd4; size_mask = 4'b1111; end
    endcase
  end

  assign legal = memory_write_enable
               ? (memory_split_option inside {3'b000, 3'b001, 3'b010})
               : (memory_split_option inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign crossing  = ({2'b00, offset} + size) > 4'd4;
  // Store bytes and lane enables spread over two words; upper half feeds SECOND.
  assign wide_data = {32'b0, write_data} << {offset, 3'b000};
  assign wide_be   = {4'b0000, size_mask} << offset;

  function automatic logic [31:0] extend(input logic [63:0] combined,
                                         input logic [1:0]  off,
                                         input logic [2:0]  opt);
    logic [31:0] s;
    s = 32'(combined >> {off, 3'b000});
    case (opt)
      3'b000:  extend = {{24{s[7]}}, s[7:0]};
      3'b001:  extend = {{16{s[15]}}, s[15:0]};
      3'b010:  extend = s;
      3'b100:  extend = {24'b0, s[7:0]};
      3'b101:  extend = {16'b0, s[15:0]};
      default: extend = 32'b0;
    endcase
  endfunction

  assign request_ready = (state == IDLE);

  always_comb begin
    state_next       = state;
    valid_next       = 1'b0;
    fault_next       = 1'b0;
    data_next        = 32'b0;
    half_index_next  = half_index;
    half_offset_next = half_offset;
    half_wdata_next  = half_wdata;
    half_low_next    = half_low;
    half_be_next     = half_be;
    half_store_next  = half_store;
    half_option_next = half_option;
    wr_en            = 1'b0;
    wr_index         = index;
    wr_be            = wide_be[3:0];
    wr_data          = wide_data[31:0];
    case (state)
      IDLE: begin
        if (request_valid && !rst) begin
          if (!legal) begin
            valid_next = 1'b1;
            fault_next = 1'b1;
          end else if (crossing) begin
            wr_en            = memory_write_enable;
            half_index_next  = index + 1'b1;
            half_offset_next = offset;
            half_wdata_next  = wide_data[63:32];
            half_be_next     = wide_be[7:4];
            half_low_next    = mem[index];
            half_store_next  = memory_write_enable;
            half_option_next = memory_split_option;
            state_next       = SECOND;
          end else begin
            wr_en      = memory_write_enable;
            valid_next = 1'b1;
            if (!memory_write_enable)
              data_next = extend({32'b0, mem[index]}, offset, memory_split_option);
          end
        end
      end
      SECOND: begin
        state_next = IDLE;
        if (!rst) begin
          wr_en      = half_store;
          wr_index   = half_index;
          wr_be      = half_be;
          wr_data    = half_wdata;
          valid_next = 1'b1;
          if (!half_store)
            data_next = extend({mem[half_index], half_low}, half_offset, half_option);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      response_valid <= 1'b0;
      read_data      <= 32'b0;
      fault          <= 1'b0;
      half_index     <= '0;
      half_offset    <= 2'b0;
      half_wdata     <= 32'b0;
      half_low       <= 32'b0;
      half_be        <= 4'b0;
      half_store     <= 1'b0;
      half_option    <= 3'b0;
    end else begin
      state          <= state_next;
      response_valid <= valid_next;
      read_data      <= data_next;
      fault          <= fault_next;
      half_index     <= half_index_next;
      half_offset    <= half_offset_next;
      half_wdata     <= half_wdata_next;
      half_low       <= half_low_next;
      half_be        <= half_be_next;
      half_store     <= half_store_next;
      half_option    <= half_option_next;
    end
  end

  // Array is deliberately not reset; writes are already suppressed under rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) mem[wr_index][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// Randomized bench for data_memory_unit against a byte-addressed reference
// model, plus directed scenarios with literal expectations.
module tb_data_memory_unit;

  localparam int DEPTH   = 1024;
  localparam int INDEX_W = 10;
  localparam int BYTES   = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        request_valid;
  logic        request_ready;
  logic        memory_write_enable;
  logic [2:0]  memory_split_option;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        response_valid;
  logic [31:0] read_data;
  logic        fault;

  data_memory_unit #(.DEPTH_WORDS(DEPTH), .INDEX_WIDTH(INDEX_W)) dut (
    .clk(clk), .rst(rst),
    .request_valid(request_valid), .request_ready(request_ready),
    .memory_write_enable(memory_write_enable),
    .memory_split_option(memory_split_option),
    .address(address), .write_data(write_data),
    .response_valid(response_valid), .read_data(read_data), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        fault;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  model_mem [BYTES];
  int          pend_addr [4];
  logic [7:0]  pend_data [4];
  int          pend_n = 0;
  logic        exp_ready = 1'b1;
  logic        ready_next;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        chk_en = 1'b0;
  logic [31:0] last_data = 32'b0;
  logic        last_fault = 1'b0;
  int          rsp_count = 0;
  logic        ev, ef;
  logic [31:0] ed;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Whole access resolved on a flat byte array; only second-word store bytes
  // are deferred, so a reset in the second cycle can discard them.
  task automatic model_accept(logic we, logic [2:0] opt, logic [31:0] a, logic [31:0] wd);
    int size, base, off, lat, b;
    logic legal;
    logic [31:0] val;
    exp_t e;
    legal = we ? (opt <= 3'd2) : (opt inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) begin
      e.due = cyc + 1; e.data = 32'b0; e.fault = 1'b1;
      q.push_back(e);
      return;
    end
    size = (opt[1:0] == 2'd0) ? 1 : (opt[1:0] == 2'd1) ? 2 : 4;
    base = int'(a[INDEX_W+1:0]);
    off  = base % 4;
    lat  = (off + size > 4) ? 2 : 1;
    val  = 32'b0;
    for (int j = 0; j < size; j++) begin
      b = (base + j) % BYTES;
      if (we) begin
        if (lat == 2 && (b / 4) != (base / 4)) begin
          pend_addr[pend_n] = b;
          pend_data[pend_n] = wd[8*j +: 8];
          pend_n++;
        end else begin
          model_mem[b] = wd[8*j +: 8];
        end
      end else begin
        val[8*j +: 8] = model_mem[b];
      end
    end
    if (!we && !opt[2] && size < 4 && val[8*size-1])
      val = val | (32'hFFFF_FFFF << (8 * size));
    e.due = cyc + lat; e.data = we ? 32'b0 : val; e.fault = 1'b0;
    q.push_back(e);
    if (lat == 2) ready_next = 1'b0;
  endtask

  task automatic step(logic v, logic we, logic [2:0] opt, logic [31:0] a,
                      logic [31:0] wd, logic r);
    request_valid = v; memory_write_enable = we; memory_split_option = opt;
    address = a; write_data = wd; rst = r;
    if (!exp_ready && !r) begin
      for (int i = 0; i < pend_n; i++) model_mem[pend_addr[i]] = pend_data[i];
    end
    if (!exp_ready) pend_n = 0;
    ready_next = 1'b1;
    if (r) begin
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].due == cyc + 1) q.delete(i);
    end else if (v && exp_ready) begin
      model_accept(we, opt, a, wd);
    end
    @(posedge clk);
    cyc++;
    #1;
    exp_ready = ready_next;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'b0, 32'b0, 32'b0, 1'b0);
  endtask

  task automatic store(logic [2:0] opt, logic [31:0] a, logic [31:0] wd);
    step(1'b1, 1'b1, opt, a, wd, 1'b0);
  endtask

  task automatic load_check(string name, logic [2:0] opt, logic [31:0] a, logic [31:0] exp);
    step(1'b1, 1'b0, opt, a, 32'b0, 1'b0);
    idle(2);
    check(name, last_data, exp);
    check({name, "_fault"}, {31'b0, last_fault}, 32'b0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      ev = 1'b0; ed = 32'b0; ef = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        ev = 1'b1; ed = q[0].data; ef = q[0].fault;
        void'(q.pop_front());
      end
      check("response_valid", {31'b0, response_valid}, {31'b0, ev});
      check("read_data", read_data, ed);
      check("fault", {31'b0, fault}, {31'b0, ef});
      check("request_ready", {31'b0, request_ready}, {31'b0, exp_ready});
      if (response_valid) begin
        last_data  = read_data;
        last_fault = fault;
        rsp_count++;
      end
    end
  end

  initial begin
    int n0, r;
    logic [2:0] opt;
    logic [31:0] a;
    logic [INDEX_W-1:0] idx;
    logic [2:0] load_opts [5];
    load_opts = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    step(1'b1, 1'b1, 3'b010, 32'h0, 32'h0, 1'b1);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1);
    check("ready_after_reset", {31'b0, request_ready}, 32'd1);

    // Preload the window of words exercised below: 0..8, DEPTH-2, DEPTH-1.
    for (int w = 0; w < 9; w++) store(3'b010, 32'(w * 4), $urandom);
    store(3'b010, 32'((DEPTH - 2) * 4), $urandom);
    store(3'b010, 32'((DEPTH - 1) * 4), $urandom);

    store(3'b010, 32'h10, 32'hDEAD_BEEF);
    idle(1);
    check("sw_fault", {31'b0, last_fault}, 32'd0);
    load_check("lw_roundtrip", 3'b010, 32'h10, 32'hDEAD_BEEF);

    store(3'b010, 32'h20, 32'h1234_5634);
    store(3'b000, 32'h21, 32'hABCD_EF80);
    load_check("lb_sign", 3'b000, 32'h21, 32'hFFFF_FF80);
    load_check("lbu_zero", 3'b100, 32'h21, 32'h0000_0080);
    load_check("lh_sign", 3'b001, 32'h20, 32'hFFFF_8034);
    load_check("lw_lanes", 3'b010, 32'h20, 32'h1234_8034);

    store(3'b010, 32'h0, 32'h0);
    store(3'b010, 32'h4, 32'h0);
    store(3'b001, 32'h3, 32'h0000_BEEF);
    check("cross_ready_low", {31'b0, request_ready}, 32'd0);
    idle(2);
    load_check("cross_word0", 3'b010, 32'h0, 32'hEF00_0000);
    load_check("cross_word1", 3'b010, 32'h4, 32'h0000_00BE);
    load_check("cross_lhu", 3'b101, 32'h3, 32'h0000_BEEF);

    store(3'b010, 32'((DEPTH - 1) * 4), 32'hA1B2_C3D4);
    store(3'b010, 32'h0, 32'h4433_2211);
    load_check("wrap_lw", 3'b010, 32'h8000_0FFE, 32'h2211_A1B2);

    n0 = rsp_count;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 3'b010, 32'(i * 4), 32'b0, 1'b0);
      check("b2b_ready", {31'b0, request_ready}, 32'd1);
    end
    idle(2);
    check("b2b_count", 32'(rsp_count - n0), 32'd8);

    step(1'b1, 1'b0, 3'b011, 32'h10, 32'b0, 1'b0);
    idle(1);
    check("illegal_load_fault", {31'b0, last_fault}, 32'd1);
    check("illegal_load_data", last_data, 32'd0);
    store(3'b100, 32'h10, 32'hFFFF_FFFF);
    idle(1);
    check("illegal_store_fault", {31'b0, last_fault}, 32'd1);
    load_check("illegal_unchanged", 3'b010, 32'h10, 32'hDEAD_BEEF);

    store(3'b010, 32'hC, 32'h0);
    store(3'b010, 32'h10, 32'h5566_7788);
    idle(2);
    n0 = rsp_count;
    store(3'b010, 32'hE, 32'h1122_3344);
    check("rst_second_ready_low", {31'b0, request_ready}, 32'd0);
    step(1'b0, 1'b0, 3'b0, 32'b0, 32'b0, 1'b1);
    check("rst_second_ready", {31'b0, request_ready}, 32'd1);
    idle(2);
    check("rst_second_no_rsp", 32'(rsp_count - n0), 32'd0);
    load_check("rst_first_half", 3'b010, 32'hC, 32'h3344_0000);
    load_check("rst_word4_kept", 3'b010, 32'h10, 32'h5566_7788);

    // Randomized traffic in the preloaded window, with aliasing upper bits.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      idx = (r < 8) ? INDEX_W'(r) : INDEX_W'(DEPTH - 10 + r);
      a = {$urandom_range(0, 1048575) , 12'b0} | {20'b0, idx, 2'(($urandom % 4))};
      if ($urandom_range(0, 1) == 1) begin
        opt = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
        step($urandom_range(0, 3) != 0, 1'b1, opt, a, $urandom, $urandom_range(0, 63) == 0);
      end else begin
        opt = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : load_opts[$urandom_range(0, 4)];
        step($urandom_range(0, 3) != 0, 1'b0, opt, a, $urandom, $urandom_range(0, 63) == 0);
      end
    end
    idle(3);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
